// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit.
// Owns the program counter. Fetches sequential words from a combinational
// instruction memory into a DEPTH-entry prefetch queue. Hands {pc, instr}
// to decode with a valid/ready handshake. Accepts redirects from downstream.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect loads the raw pc, flushes the queue and
//               parks in TRAP with misalign=1 until a legal redirect or reset.
//   undefined : redirect_pc[1:0] is ignored and misalign is tied 0.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   imem_addr      out  byte address to instruction memory (always pc)
//   imem_instr     in   instruction at imem_addr, same cycle
//   out_valid      out  queue head valid
//   out_ready      in   decode accepts head
//   out_instr      out  head instruction (0 when not valid)
//   out_pc         out  head byte address (0 when not valid)
//   redirect_valid in   redirect request
//   redirect_pc    in   redirect target byte address
//   done           out  fetch stopped at end of memory (END state)
//   misalign       out  misaligned-redirect trap (TRAP state)
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd40,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 250
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_END   = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     w_pc_nxt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [31:0]     r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];

  logic            w_deq;
  logic            w_enq;
  logic [31:0]     w_redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            w_redir_mis;
  assign w_redir_mis = (redirect_pc[1:0] != 2'b00);
  assign w_redir_pc  = redirect_pc;
`else
  logic            w_unused_lo;
  assign w_unused_lo = ^redirect_pc[1:0];
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
`endif

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_q_pc[r_head]    : '0;
  assign out_instr = out_valid ? r_q_instr[r_head] : '0;
  assign imem_addr = r_pc;
  assign done      = (r_state == ST_END);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign  = (r_state == ST_TRAP);
`else
  assign misalign  = 1'b0;
`endif

  assign w_deq = out_valid & out_ready;
  // A full queue may still accept when its head leaves in the same cycle.
  assign w_enq = (r_state == ST_FETCH) & ((r_count < CW'(DEPTH)) | w_deq)
               & ~redirect_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (redirect_valid) begin
      w_pc_nxt = w_redir_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_redir_mis)
        w_state_nxt = ST_TRAP;
      else
`endif
      if (w_redir_pc >= LIMIT)
        w_state_nxt = ST_END;
      else
        w_state_nxt = ST_FETCH;
    end else if (r_state == ST_FETCH) begin
      if (w_enq)
        w_pc_nxt = r_pc + 32'd4;
      // Stopping on the incremented pc keeps pc+4 from ever wrapping.
      if (w_pc_nxt >= LIMIT)
        w_state_nxt = ST_END;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_enq && !w_deq)
        r_count <= r_count + CW'(1);
      else if (!w_enq && w_deq)
        r_count <= r_count - CW'(1);
      if (w_enq)
        r_tail <= r_tail + PW'(1);
      if (w_deq)
        r_head <= r_head + PW'(1);
    end
  end

  // Payload storage needs no reset: out_valid gates what is visible.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_tail]    <= r_pc;
      r_q_instr[r_tail] <= imem_instr;
    end
  end

endmodule
